// File: rtl/conv_encode_param.sv
// Rate-1/N convolutional encoder with generic K, generators and framing.
// Valid/ready on both sides, optional zero-tail flush per frame.
module conv_encode_param #(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = {3'b101, 3'b111},
  parameter int FRAME_LEN = 64,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic         clk_sig,
  input  logic         rst_sig,
  input  logic         en_sig,
  input  logic         start_sig,
  input  logic         in_bit,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] encode_sig,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         last_sig,
  output logic         busy_sig
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic [1:0]    st_q, st_d;
  logic [K-2:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [N-1:0]  enc_q, enc_d;
  logic          ov_q, ov_d;
  logic          last_q, last_d;

  logic [N-1:0]  cw;
  logic [K-1:0]  win;
  logic          slot_free;
  logic          cur_bit;
  logic          take;
  logic          tail_go;
  logic          produce;
  logic          last_new;

  // Window: MSB is the current bit, LSB the oldest held bit.
  always_comb begin
    slot_free = !ov_q || out_ready;
    cur_bit   = (st_q == S_DATA) && in_bit;
    win       = {cur_bit, sr_q};
    for (int n = 0; n < N; n++) begin
      cw[n] = ^(win & G[n*K +: K]);
    end
    in_ready = (st_q == S_DATA) && en_sig && slot_free;
    take     = in_ready && in_valid;
    tail_go  = (st_q == S_TAIL) && en_sig && slot_free;
    produce  = take || tail_go;
  end

  always_comb begin
    st_d     = st_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    last_new = 1'b0;
    unique case (1'b1)
      (st_q == S_IDLE): begin
        if (en_sig && start_sig) begin
          sr_d   = '0;
          cnt_d  = '0;
          tcnt_d = '0;
          st_d   = S_DATA;
        end
      end
      (st_q == S_DATA): begin
        if (take) begin
          sr_d  = win[K-1:1];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(FRAME_LEN - 1)) begin
            if (TAIL_EN) begin
              tcnt_d = '0;
              st_d   = S_TAIL;
            end else begin
              last_new = 1'b1;
              st_d     = S_IDLE;
            end
          end
        end
      end
      (st_q == S_TAIL): begin
        if (tail_go) begin
          sr_d   = win[K-1:1];
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(K - 2)) begin
            last_new = 1'b1;
            st_d     = S_IDLE;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Output register: reload on produce, drop on consume-only.
  always_comb begin
    enc_d  = enc_q;
    ov_d   = ov_q;
    last_d = last_q;
    if (produce) begin
      enc_d  = cw;
      ov_d   = 1'b1;
      last_d = last_new;
    end else if (en_sig && ov_q && out_ready) begin
      ov_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      st_q   <= S_IDLE;
      sr_q   <= '0;
      cnt_q  <= '0;
      tcnt_q <= '0;
      enc_q  <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      tcnt_q <= tcnt_d;
      enc_q  <= enc_d;
      ov_q   <= ov_d;
      last_q <= last_d;
    end
  end

  assign encode_sig = enc_q;
  assign out_valid  = ov_q;
  assign last_sig   = last_q;
  assign busy_sig   = (st_q != S_IDLE);

endmodule

// File: tb/tb_conv_encode_param.sv
// Bench for conv_encode_param: three configurations checked against
// a convolution-sum reference model.
module tb_conv_encode_param;

  localparam logic [5:0]  GA = {3'b101, 3'b111};
  localparam logic [11:0] GC = {4'b1101, 4'b1011, 4'b1111};

  logic clk = 1'b0;
  logic rst, en, start, in_bit, in_valid, out_ready;

  logic       a_ir, a_ov, a_last, a_busy;
  logic [1:0] a_enc;
  logic       b_ir, b_ov, b_last, b_busy;
  logic [1:0] b_enc;
  logic       c_ir, c_ov, c_last, c_busy;
  logic [2:0] c_enc;

  int   n_chk = 0;
  int   n_fail = 0;
  logic seq [0:63];
  int   nin, idx;

  always #5 clk = ~clk;

  conv_encode_param #(
    .K(3), .N(2), .G(GA), .FRAME_LEN(4), .TAIL_EN(1'b1)
  ) dut_a (
    .clk_sig(clk), .rst_sig(rst), .en_sig(en),
    .start_sig(start), .in_bit(in_bit),
    .in_valid(in_valid), .in_ready(a_ir),
    .encode_sig(a_enc), .out_valid(a_ov),
    .out_ready(out_ready), .last_sig(a_last),
    .busy_sig(a_busy)
  );

  conv_encode_param #(
    .K(3), .N(2), .G(GA), .FRAME_LEN(4), .TAIL_EN(1'b0)
  ) dut_b (
    .clk_sig(clk), .rst_sig(rst), .en_sig(en),
    .start_sig(start), .in_bit(in_bit),
    .in_valid(in_valid), .in_ready(b_ir),
    .encode_sig(b_enc), .out_valid(b_ov),
    .out_ready(out_ready), .last_sig(b_last),
    .busy_sig(b_busy)
  );

  conv_encode_param #(
    .K(4), .N(3), .G(GC), .FRAME_LEN(1), .TAIL_EN(1'b1)
  ) dut_c (
    .clk_sig(clk), .rst_sig(rst), .en_sig(en),
    .start_sig(start), .in_bit(in_bit),
    .in_valid(in_valid), .in_ready(c_ir),
    .encode_sig(c_enc), .out_valid(c_ov),
    .out_ready(out_ready), .last_sig(c_last),
    .busy_sig(c_busy)
  );

  // Output o at time t = XOR over taps j of g[o*k+j] * bit[t-(k-1-j)].
  function automatic logic [3:0] ref_cw(input int k, input int n,
                                        input logic [11:0] g,
                                        input int t);
    logic [3:0] r;
    logic       p;
    int         b;
    r = '0;
    for (int o = 0; o < n; o++) begin
      p = 1'b0;
      for (int j = 0; j < k; j++) begin
        b = t - (k - 1 - j);
        if (b >= 0 && g[o*k+j]) p = p ^ seq[b];
      end
      r[o] = p;
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) seq[i] = 1'b0;
    nin = 0;
    idx = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({a_ov, a_last, a_ir, a_busy, a_enc} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a got %b want 000000",
               {a_ov, a_last, a_ir, a_busy, a_enc});
    end
    n_chk++;
    if ({b_ov, b_last, b_ir, b_busy, b_enc} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_b got %b want 000000",
               {b_ov, b_last, b_ir, b_busy, b_enc});
    end
    n_chk++;
    if ({c_ov, c_last, c_ir, c_busy, c_enc} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_c got %b want 0000000",
               {c_ov, c_last, c_ir, c_busy, c_enc});
    end
    @(negedge clk);
    en = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (a_ir !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_in_ready got %b want 0", a_ir);
    end
  endtask

  task automatic test_basic();
    logic [1:0] tbl [0:5];
    logic       bits [0:3];
    int         cyc;
    tbl  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    pulse_start();
    cyc = 0;
    while (idx < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      en = 1'b1;
      out_ready = 1'b1;
      in_valid = (nin < 4);
      if (nin < 4) in_bit = bits[nin];
      else in_bit = 1'b0;
      #1;
      if (a_ov && out_ready) begin
        n_chk++;
        if (a_enc !== tbl[idx] || a_last !== (idx == 5)) begin
          n_fail++;
          $display("FAIL basic_cw%0d got %b/%b want %b/%b", idx,
                   a_enc, a_last, tbl[idx], idx == 5);
        end
        n_chk++;
        if (a_busy !== (idx != 5)) begin
          n_fail++;
          $display("FAIL basic_busy%0d got %b want %b", idx,
                   a_busy, idx != 5);
        end
        idx++;
      end
      if (a_ir && in_valid) nin++;
      @(posedge clk);
    end
    if (idx < 6) begin
      n_chk++;
      n_fail++;
      $display("FAIL basic_timeout got %0d want 6", idx);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (a_ov !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain got %b%b want 00", a_ov, a_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] tbl [0:5];
    logic       bits [0:3];
    int         cyc, stall;
    logic       stall_now;
    tbl  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    pulse_start();
    cyc = 0;
    stall = 0;
    while (idx < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      en = 1'b1;
      stall_now = a_ov && idx == 1 && stall < 3;
      out_ready = !stall_now;
      in_valid = (nin < 4);
      if (nin < 4) in_bit = bits[nin];
      else in_bit = 1'b0;
      #1;
      if (stall_now) begin
        n_chk++;
        if (a_enc !== 2'b01 || a_ir !== 1'b0 || a_ov !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold got enc=%b ir=%b ov=%b want 01/0/1",
                   a_enc, a_ir, a_ov);
        end
        stall++;
      end
      if (a_ov && out_ready) begin
        n_chk++;
        if (a_enc !== tbl[idx] || a_last !== (idx == 5)) begin
          n_fail++;
          $display("FAIL bp_cw%0d got %b/%b want %b/%b", idx,
                   a_enc, a_last, tbl[idx], idx == 5);
        end
        idx++;
      end
      if (a_ir && in_valid) nin++;
      @(posedge clk);
    end
    n_chk++;
    if (idx != 6 || stall != 3) begin
      n_fail++;
      $display("FAIL bp_count got %0d/%0d want 6/3", idx, stall);
    end
  endtask

  task automatic test_enable();
    logic [1:0] tbl [0:5];
    logic       bits [0:3];
    logic [4:0] snap;
    int         cyc, off;
    logic       frz;
    tbl  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    pulse_start();
    cyc = 0;
    off = 0;
    snap = '0;
    while (idx < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      frz = (idx == 2 && off < 5);
      en = !frz;
      out_ready = 1'b1;
      in_valid = (nin < 4);
      if (nin < 4) in_bit = bits[nin];
      else in_bit = 1'b0;
      #1;
      if (frz) begin
        if (off == 0) snap = {a_ov, a_last, a_busy, a_enc};
        n_chk++;
        if (a_ir !== 1'b0 || a_ov !== 1'b1 ||
            {a_ov, a_last, a_busy, a_enc} !== snap) begin
          n_fail++;
          $display("FAIL en_freeze got ir=%b st=%b want 0/%b",
                   a_ir, {a_ov, a_last, a_busy, a_enc}, snap);
        end
        off++;
      end
      if (a_ov && out_ready && en) begin
        n_chk++;
        if (a_enc !== tbl[idx] || a_last !== (idx == 5)) begin
          n_fail++;
          $display("FAIL en_cw%0d got %b/%b want %b/%b", idx,
                   a_enc, a_last, tbl[idx], idx == 5);
        end
        idx++;
      end
      if (a_ir && in_valid) nin++;
      @(posedge clk);
    end
    n_chk++;
    if (idx != 6 || off != 5) begin
      n_fail++;
      $display("FAIL en_count got %0d/%0d want 6/5", idx, off);
    end
  endtask

  task automatic test_notail();
    logic [1:0] tbl [0:3];
    logic       bits [0:3];
    int         cyc;
    tbl  = '{2'b11, 2'b01, 2'b00, 2'b10};
    bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    pulse_start();
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      en = 1'b1;
      out_ready = 1'b1;
      in_valid = (nin < 4);
      if (nin < 4) in_bit = bits[nin];
      else in_bit = 1'b0;
      #1;
      if (b_ov && out_ready) begin
        n_chk++;
        if (b_enc !== tbl[idx] || b_last !== (idx == 3)) begin
          n_fail++;
          $display("FAIL nt_cw%0d got %b/%b want %b/%b", idx,
                   b_enc, b_last, tbl[idx], idx == 3);
        end
        idx++;
      end
      if (b_ir && in_valid) nin++;
      @(posedge clk);
    end
    n_chk++;
    if (idx != 4 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nt_end got %0d/%b want 4/0", idx, b_busy);
    end
    pulse_start();
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      en = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_bit = 1'b0;
      #1;
      if (b_ov) break;
      @(posedge clk);
    end
    n_chk++;
    if (b_ov !== 1'b1 || b_enc !== 2'b00) begin
      n_fail++;
      $display("FAIL nt_restart got %b/%b want 1/00", b_ov, b_enc);
    end
  endtask

  task automatic test_reset_tail();
    logic [3:0] e;
    int         cyc;
    do_reset();
    pulse_start();
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (idx == 4) begin
        rst = 1'b1;
        #1;
        n_chk++;
        if ({a_ov, a_busy, a_last, a_enc} !== 5'b0) begin
          n_fail++;
          $display("FAIL rst_async got %b want 00000",
                   {a_ov, a_busy, a_last, a_enc});
        end
        break;
      end
      en = 1'b1;
      out_ready = 1'b1;
      in_valid = (nin < 4);
      in_bit = 1'($urandom_range(0, 1));
      #1;
      if (a_ov && out_ready) idx++;
      if (a_ir && in_valid) nin++;
      @(posedge clk);
    end
    n_chk++;
    if (idx != 4) begin
      n_fail++;
      $display("FAIL rst_reach got %0d want 4", idx);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    pulse_start();
    cyc = 0;
    while (idx < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      en = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (nin < 4);
      in_bit = 1'($urandom_range(0, 1));
      #1;
      if (a_ov && out_ready) begin
        e = ref_cw(3, 2, 12'(GA), idx);
        n_chk++;
        if (a_enc !== e[1:0] || a_last !== (idx == 5)) begin
          n_fail++;
          $display("FAIL rst_cw%0d got %b/%b want %b/%b", idx,
                   a_enc, a_last, e[1:0], idx == 5);
        end
        idx++;
      end
      if (a_ir && in_valid) begin
        seq[nin] = in_bit;
        nin++;
      end
      @(posedge clk);
    end
    n_chk++;
    if (idx != 6) begin
      n_fail++;
      $display("FAIL rst_frame got %0d want 6", idx);
    end
  endtask

  task automatic test_k4();
    logic [3:0] e;
    int         cyc, extra;
    do_reset();
    pulse_start();
    cyc = 0;
    while (idx < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      en = 1'b1;
      out_ready = 1'b1;
      in_valid = (nin < 1);
      in_bit = 1'b1;
      #1;
      if (c_ov && out_ready) begin
        e = ref_cw(4, 3, GC, idx);
        n_chk++;
        if (c_enc !== e[2:0] || c_last !== (idx == 3)) begin
          n_fail++;
          $display("FAIL k4_cw%0d got %b/%b want %b/%b", idx,
                   c_enc, c_last, e[2:0], idx == 3);
        end
        if (idx == 0) begin
          n_chk++;
          if (c_enc !== 3'b111) begin
            n_fail++;
            $display("FAIL k4_first got %b want 111", c_enc);
          end
        end
        idx++;
      end
      if (c_ir && in_valid) begin
        seq[nin] = in_bit;
        nin++;
      end
      @(posedge clk);
    end
    extra = 0;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (c_ov) extra++;
    end
    n_chk++;
    if (idx != 4 || extra != 0 || c_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL k4_count got %0d/%0d/%b want 4/0/0",
               idx, extra, c_busy);
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    int         cyc;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      clear_model();
      pulse_start();
      cyc = 0;
      while (idx < 6 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        en = ($urandom_range(0, 5) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
        in_bit = 1'($urandom_range(0, 1));
        #1;
        if (a_ir && !en) begin
          n_chk++;
          n_fail++;
          $display("FAIL rnd_ir_en got 1 want 0");
        end
        if (a_ov && out_ready && en) begin
          e = ref_cw(3, 2, 12'(GA), idx);
          n_chk++;
          if (a_enc !== e[1:0] || a_last !== (idx == 5)) begin
            n_fail++;
            $display("FAIL rnd_f%0d_cw%0d got %b/%b want %b/%b",
                     f, idx, a_enc, a_last, e[1:0], idx == 5);
          end
          idx++;
        end
        if (a_ir && in_valid) begin
          n_chk++;
          if (nin >= 4) begin
            n_fail++;
            $display("FAIL rnd_extra_bit got %0d want <4", nin);
          end else begin
            seq[nin] = in_bit;
          end
          nin++;
        end
        @(posedge clk);
      end
      n_chk++;
      if (idx != 6) begin
        n_fail++;
        $display("FAIL rnd_f%0d_timeout got %0d want 6", f, idx);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_enable();
    test_notail();
    test_reset_tail();
    test_k4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_encode_param.md
Name: conv_encode_param

Overview:
- Parametrised rate-1/N convolutional encoder. Successor to the fixed K=3, rate-1/2 encoder in the service layer.
- Adds generic constraint length, generic generator polynomials and frame-based operation with an optional zero-tail flush.
- Uses valid/ready handshakes on both sides. Sits between the bit source (m-series generator or framer) and the BPSK mapper.

Parameters:
- K, 3, constraint length (2..9); the shift register holds K-1 past bits.
- N, 2, number of coded output bits per input bit (2..4).
- G, {3'b101,3'b111}, packed generators, N*K bits. G[n*K +: K] is the generator for output n.
- FRAME_LEN, 64, information bits per frame (>=1).
- TAIL_EN, 1, 1 = append K-1 zero tail bits per frame; 0 = no tail, state not forced to zero.

Ports:
- clk_sig  in  1  system clock, rising edge.
- rst_sig  in  1  asynchronous, active-high reset.
- en_sig  in  1  global enable; 0 freezes all state.
- start_sig  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- in_bit  in  1  information bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- encode_sig  out  N  codeword; encode_sig[n] = output n.
- out_valid  out  1  encode_sig is valid.
- out_ready  in  1  downstream consumes encode_sig.
- last_sig  out  1  qualifies the final codeword of a frame.
- busy_sig  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_sig=1): state=IDLE, shift register=0, bit counter=0, encode_sig=0, out_valid=0, last_sig=0, in_ready=0, busy_sig=0.
- Window w (K bits):
  - w[K-1] = current bit; w[K-2] = previous bit; ...; w[0] = oldest.
  - Output n = XOR-reduce(w & G[n*K +: K]).
  - After each encode, the shift register takes w[K-1:1].
- Output slot free = !out_valid || out_ready.
- States:
  - IDLE: in_ready=0. On start_sig & en_sig: clear shift register and counter, go to DATA.
  - DATA: in_ready = en_sig & slot free. On in_valid & in_ready: encode, load encode_sig, out_valid=1, counter+1. When the counter reaches FRAME_LEN: go to TAIL if TAIL_EN, else IDLE with last_sig=1 on that codeword.
  - TAIL: in_ready=0. Each cycle with en_sig & slot free: encode current bit 0 and increment the tail counter. The (K-1)th tail codeword carries last_sig=1, then go to IDLE.
- Latency: one cycle; a codeword appears on the clock edge that accepts its bit.
- Back-pressure: with out_valid=1 & out_ready=0, encode_sig, last_sig and out_valid hold; in_ready=0; TAIL stalls.
- Simultaneous consume and produce (out_ready=1, new encode): register reloads, out_valid stays 1, so 1 codeword/cycle sustained.
- Consume without produce: out_valid clears to 0 the next cycle.
- last_sig clears when its codeword is consumed.
- en_sig=0: no state, counter or register updates; in_ready=0; outputs hold; out_valid is not cleared even if out_ready=1.
- start_sig outside IDLE: ignored.
- After a TAIL_EN frame the shift register returns to 0.
- Counter width: $clog2(FRAME_LEN+1); no wrap within a frame.
- Reset mid-frame: immediate return to reset values; any pending codeword is discarded.

Test Plan:
- K=3, G={101,111}, FRAME_LEN=4, TAIL_EN=1, out_ready=1; start, then bits 1,0,1,1 -> encode_sig 11,01,00,10, then tail 10,11 with last_sig on 11; busy_sig drops the next cycle; shift register = 0.
- Same stimulus, out_ready low for 3 cycles after the 2nd codeword -> encode_sig holds 01, in_ready=0, no bit lost; the sequence then resumes unchanged.
- TAIL_EN=0, FRAME_LEN=4, bits 1,0,1,1 -> 11,01,00,10 with last_sig on 10; next frame's first bit 0 -> 00 (register cleared at start).
- en_sig=0 for 5 cycles mid-frame with in_valid=1 -> in_ready=0, outputs frozen; the sequence is identical after en_sig=1.
- rst_sig asserted mid-TAIL -> out_valid=0, busy_sig=0, encode_sig=0 immediately (asynchronous); a new start_sig encodes the frame from a zero state.
- K=4, N=3, G={4'b1101,4'b1011,4'b1111}, single bit 1 then tail -> first codeword 3'b111; exactly 3 tail codewords follow.
